mac_dot_sequencer: RTL and testbench

Controller that sequences the team's 8-bit multiply-accumulate datapath (16-bit accumulator, low byte always driven, upper byte on a shared tri-state pad) through a complete dot-product job. It clears the accumulator, optionally preloads a bias into the upper byte, streams N operand pairs over a valid/ready interface, and returns the 16-bit result as two byte beats. It sits between the host-side job/operand interface and the MAC, and it is the only block that drives the MAC's control pins.

---
 rtl/mac_ctrl_pkg.sv | 56 +++++
 rtl/mac_dot_sequencer_if.sv | 60 ++++++
 rtl/mac_dot_sequencer.sv | 96 +++++++++
 tb/tb_mac_dot_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC dot-product sequencer: FSM states, default
// widths, pad-ownership encoding and the per-state control decode.
package mac_ctrl_pkg;

  localparam int LEN_W_DEF = 5;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    BIAS   = 3'd2,
    ACCUM  = 3'd3,
    OUT_LO = 3'd4,
    OUT_HI = 3'd5
  } state_t;

  // Bit 1: controller drives the pad, bit 0: MAC drives the pad.
  // Exactly one bit is set in each code, so the pad always has one owner.
  typedef logic [1:0] pad_own_t;
  localparam pad_own_t PAD_MAC  = 2'b01;
  localparam pad_own_t PAD_CTRL = 2'b10;

  typedef struct packed {
    logic     busy;
    logic     op_ready;
    logic     mac_rst_n;
    logic     load_ext_high;
    pad_own_t pad_own;
    logic     res_valid;
    logic     res_last;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c               = '0;
    c.busy          = (s != IDLE);
    c.mac_rst_n     = 1'b1;
    c.pad_own       = PAD_MAC;
    case (s)
      CLEAR:   c.mac_rst_n = 1'b0;
      BIAS: begin
        c.pad_own       = PAD_CTRL;
        c.load_ext_high = 1'b1;
      end
      ACCUM:   c.op_ready = 1'b1;
      OUT_LO:  c.res_valid = 1'b1;
      OUT_HI: begin
        c.res_valid = 1'b1;
        c.res_last  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Host job/operand/result handshakes plus the MAC control pins of the
// dot-product sequencer. slave = sequencer view, master = host/MAC side.
interface mac_dot_sequencer_if
  import mac_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              use_bias;
  logic [DATA_W-1:0] bias_hi;
  logic              busy;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              mac_rst_n;
  logic              mac_acc_en;
  logic [DATA_W-1:0] mac_in_a;
  logic [DATA_W-1:0] mac_in_b;
  logic              mac_io_drive;
  logic              mac_load_ext_high;
  logic              pad_oe;
  logic [DATA_W-1:0] pad_out;
  logic [DATA_W-1:0] mac_out_low;
  logic [DATA_W-1:0] mac_pad_in;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_byte;
  logic              res_last;

  modport slave (
    input  start, len, use_bias, bias_hi,
    output busy,
    input  op_valid, op_a, op_b,
    output op_ready,
    output mac_rst_n, mac_acc_en, mac_in_a, mac_in_b,
    output mac_io_drive, mac_load_ext_high, pad_oe, pad_out,
    input  mac_out_low, mac_pad_in,
    output res_valid, res_byte, res_last,
    input  res_ready
  );

  modport master (
    output start, len, use_bias, bias_hi,
    input  busy,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  mac_rst_n, mac_acc_en, mac_in_a, mac_in_b,
    input  mac_io_drive, mac_load_ext_high, pad_oe, pad_out,
    output mac_out_low, mac_pad_in,
    input  res_valid, res_byte, res_last,
    output res_ready
  );

endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences the 8-bit MAC through clear, optional bias preload, N operand
// pairs and a two-beat result readout. Sole driver of the MAC control pins.
module mac_dot_sequencer
  import mac_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mac_dot_sequencer_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  ctrl_t             r_ctrl;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_use_bias;
  logic [DATA_W-1:0] r_bias;

  logic              w_start_acc;
  logic              w_pair_acc;
  logic              w_res_acc;
  logic              w_last_pair;
  logic              w_have_pairs;

  assign w_start_acc  = (r_state == IDLE) && bus.start;
  assign w_pair_acc   = (r_state == ACCUM) && bus.op_valid;
  assign w_res_acc    = r_ctrl.res_valid && bus.res_ready;
  assign w_last_pair  = (r_cnt == LEN_W'(1));
  assign w_have_pairs = (r_cnt != '0);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start_acc) w_next = CLEAR;
      CLEAR: begin
        if (r_use_bias)        w_next = BIAS;
        else if (w_have_pairs) w_next = ACCUM;
        else                   w_next = OUT_LO;
      end
      BIAS:    w_next = w_have_pairs ? ACCUM : OUT_LO;
      ACCUM:   if (w_pair_acc && w_last_pair) w_next = OUT_LO;
      OUT_LO:  if (w_res_acc) w_next = OUT_HI;
      OUT_HI:  if (w_res_acc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so every Moore
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ctrl     <= ctrl_decode(IDLE);
      r_cnt      <= '0;
      r_use_bias <= 1'b0;
      r_bias     <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_decode(w_next);
      if (w_start_acc) begin
        r_cnt      <= bus.len;
        r_use_bias <= bus.use_bias;
        r_bias     <= bus.bias_hi;
      end else if (w_pair_acc) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  assign bus.busy              = r_ctrl.busy;
  assign bus.op_ready          = r_ctrl.op_ready;
  assign bus.mac_rst_n         = r_ctrl.mac_rst_n;
  assign bus.mac_load_ext_high = r_ctrl.load_ext_high;
  assign bus.pad_oe            = r_ctrl.pad_own[1];
  assign bus.mac_io_drive      = r_ctrl.pad_own[0];
  assign bus.pad_out           = r_bias;
  assign bus.res_valid         = r_ctrl.res_valid;
  assign bus.res_last          = r_ctrl.res_last;

  // The only Mealy path: operands reach the MAC in the cycle they are accepted.
  assign bus.mac_acc_en = w_pair_acc;
  assign bus.mac_in_a   = w_pair_acc ? bus.op_a : '0;
  assign bus.mac_in_b   = w_pair_acc ? bus.op_b : '0;

  // Result bytes come straight from the MAC so the final pair is visible.
  always_comb begin
    bus.res_byte = '0;
    case (r_state)
      OUT_LO:  bus.res_byte = bus.mac_out_low;
      OUT_HI:  bus.res_byte = bus.mac_pad_in;
      default: bus.res_byte = '0;
    endcase
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural 16-bit MAC and
// shared-pad model attached to the control pins.
module tb_mac_dot_sequencer;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   c0;
  int   pad_conflicts = 0;
  int   pad_undriven  = 0;

  logic [15:0] acc = '0;
  logic [7:0]  pad;

  mac_dot_sequencer_if #(.LEN_W(5)) bus ();

  mac_dot_sequencer #(.LEN_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC: sync clear, upper-byte capture from pad, else accumulate
  always @(posedge clk) begin
    if (bus.mac_rst_n === 1'b0)              acc <= '0;
    else if (bus.mac_load_ext_high === 1'b1) acc[15:8] <= pad;
    else if (bus.mac_acc_en === 1'b1)        acc <= acc + bus.mac_in_a * bus.mac_in_b;
  end

  always_comb begin
    pad = 8'h00;
    if (bus.pad_oe === 1'b1)            pad = bus.pad_out;
    else if (bus.mac_io_drive === 1'b1) pad = acc[15:8];
  end

  assign bus.mac_out_low = acc[7:0];
  assign bus.mac_pad_in  = pad;

  always @(negedge clk) begin
    if (bus.pad_oe === 1'b1 && bus.mac_io_drive === 1'b1) pad_conflicts++;
    if (bus.pad_oe === 1'b0 && bus.mac_io_drive === 1'b0 && bus.mac_load_ext_high === 1'b0)
      pad_undriven++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},       16'(bus.busy), 16'd0);
    check({tag, " op_ready"},   16'(bus.op_ready), 16'd0);
    check({tag, " mac_rst_n"},  16'(bus.mac_rst_n), 16'd1);
    check({tag, " acc_en"},     16'(bus.mac_acc_en), 16'd0);
    check({tag, " mac_in_a"},   16'(bus.mac_in_a), 16'd0);
    check({tag, " mac_in_b"},   16'(bus.mac_in_b), 16'd0);
    check({tag, " io_drive"},   16'(bus.mac_io_drive), 16'd1);
    check({tag, " load_ext"},   16'(bus.mac_load_ext_high), 16'd0);
    check({tag, " pad_oe"},     16'(bus.pad_oe), 16'd0);
    check({tag, " pad_out"},    16'(bus.pad_out), 16'd0);
    check({tag, " res_valid"},  16'(bus.res_valid), 16'd0);
    check({tag, " res_byte"},   16'(bus.res_byte), 16'd0);
    check({tag, " res_last"},   16'(bus.res_last), 16'd0);
  endtask

  // Accept the job at the next edge; returns in the CLEAR cycle.
  task automatic start_job(input logic [4:0] l, input logic ub, input logic [7:0] bh);
    bus.start    = 1'b1;
    bus.len      = l;
    bus.use_bias = ub;
    bus.bias_hi  = bh;
    step();
    bus.start = 1'b0;
    c0 = cyc;
    check("clear busy", 16'(bus.busy), 16'd1);
    check("clear mac_rst_n", 16'(bus.mac_rst_n), 16'd0);
  endtask

  task automatic feed_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
    int n;
    bus.op_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      #1;
      if (bus.op_ready) check("gap acc_en", 16'(bus.mac_acc_en), 16'd0);
      step();
    end
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    n = 0;
    while (!bus.op_ready && n < 20) begin
      step();
      n++;
    end
    #1;
    check("op_ready", 16'(bus.op_ready), 16'd1);
    check("acc_en", 16'(bus.mac_acc_en), 16'd1);
    check("mac_in_a", 16'(bus.mac_in_a), 16'(a));
    check("mac_in_b", 16'(bus.mac_in_b), 16'(b));
    step();
    bus.op_valid = 1'b0;
  endtask

  task automatic read_result(input logic [7:0] lo, input logic [7:0] hi, input int stall);
    int n;
    bus.res_ready = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 40) begin
      step();
      n++;
    end
    check("lo valid", 16'(bus.res_valid), 16'd1);
    check("lo byte", 16'(bus.res_byte), 16'(lo));
    check("lo last", 16'(bus.res_last), 16'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall valid", 16'(bus.res_valid), 16'd1);
      check("stall byte", 16'(bus.res_byte), 16'(lo));
      check("stall last", 16'(bus.res_last), 16'd0);
    end
    bus.res_ready = 1'b1;
    step();
    check("hi valid", 16'(bus.res_valid), 16'd1);
    check("hi byte", 16'(bus.res_byte), 16'(hi));
    check("hi last", 16'(bus.res_last), 16'd1);
    step();
    bus.res_ready = 1'b0;
    check("done busy", 16'(bus.busy), 16'd0);
    check("done valid", 16'(bus.res_valid), 16'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.use_bias = 1'b0;
    bus.bias_hi  = '0;
    bus.op_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // len=3, no bias, back-to-back: 6+20+100 = 0x007E in 6 cycles
    start_job(5'd3, 1'b0, 8'h00);
    feed_pair(8'd2, 8'd3, 0);
    feed_pair(8'd4, 8'd5, 0);
    feed_pair(8'd10, 8'd10, 0);
    read_result(8'h7E, 8'h00, 0);
    check("len3 job cycles", 16'(cyc - c0), 16'd6);

    // len=1, bias 0x12, 0xFF*0xFF: 0x1200+0xFE01 wraps to 0x1001
    start_job(5'd1, 1'b1, 8'h12);
    check("clear pad_oe", 16'(bus.pad_oe), 16'd0);
    step();
    check("bias pad_oe", 16'(bus.pad_oe), 16'd1);
    check("bias io_drive", 16'(bus.mac_io_drive), 16'd0);
    check("bias load_ext", 16'(bus.mac_load_ext_high), 16'd1);
    check("bias acc_en", 16'(bus.mac_acc_en), 16'd0);
    check("bias pad_out", 16'(bus.pad_out), 16'h12);
    check("bias pad value", 16'(bus.mac_pad_in), 16'h12);
    feed_pair(8'hFF, 8'hFF, 0);
    read_result(8'h01, 8'h10, 0);

    // len=0 with bias 0xAB: straight from BIAS to readout
    start_job(5'd0, 1'b1, 8'hAB);
    step();
    check("len0 bias load_ext", 16'(bus.mac_load_ext_high), 16'd1);
    check("len0 bias op_ready", 16'(bus.op_ready), 16'd0);
    read_result(8'h00, 8'hAB, 0);

    // len=0, no bias: 3-cycle job returning zero
    start_job(5'd0, 1'b0, 8'h00);
    read_result(8'h00, 8'h00, 0);
    check("len0 job cycles", 16'(cyc - c0), 16'd3);

    // len=4 gapped (1,1) pairs, spurious start while busy, 3-cycle result stall
    start_job(5'd4, 1'b0, 8'h00);
    bus.start    = 1'b1;
    bus.len      = 5'd7;
    bus.use_bias = 1'b1;
    bus.bias_hi  = 8'h55;
    for (int i = 0; i < 4; i++) feed_pair(8'd1, 8'd1, 1);
    bus.start = 1'b0;
    check("busy start pad_out", 16'(bus.pad_out), 16'h00);
    read_result(8'h04, 8'h00, 3);

    // Reset in the 2nd ACCUM cycle, then a clean len=1 job with (3,3)
    start_job(5'd3, 1'b0, 8'h00);
    bus.op_valid = 1'b1;
    bus.op_a     = 8'd5;
    bus.op_b     = 8'd5;
    step();
    step();
    check("abort accum op_ready", 16'(bus.op_ready), 16'd1);
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    step();
    check_reset_outputs("abort");
    rst_n = 1'b1;
    step();
    check("abort idle busy", 16'(bus.busy), 16'd0);
    start_job(5'd1, 1'b0, 8'h00);
    feed_pair(8'd3, 8'd3, 0);
    read_result(8'h09, 8'h00, 0);

    check("pad both driven", 16'(pad_conflicts), 16'd0);
    check("pad undriven", 16'(pad_undriven), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
